// File: rtl/memory_operation_controller.sv
// Load/store sequencer: turns one control-unit request into big-endian byte
// accesses on a byte-wide synchronous RAM and reports completion via MOC.
module memory_operation_controller #(
    parameter int ADDR_WIDTH  = 9,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_memory_operation_valid,
    input  logic                  i_read_write,
    input  logic [1:0]            i_data_type,
    input  logic                  i_sign_extend,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [31:0]           i_data_in,
    output logic [31:0]           o_data_out,
    output logic                  o_memory_operation_complete,
    output logic                  o_alignment_error,
    output logic                  o_ram_enable,
    output logic                  o_ram_write,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [7:0]            o_ram_data_out,
    input  logic [7:0]            i_ram_data_in
);
    localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;

    state_t                r_state;
    logic [1:0]            r_k;
    logic [CW-1:0]         r_wait_cnt;
    logic                  r_read_write;
    logic [1:0]            r_data_type;
    logic                  r_sign_extend;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [31:0]           r_data;
    logic                  r_error;
    logic [31:0]           r_asm;
    logic [31:0]           r_data_out;
    logic                  r_moc;
    logic                  r_alignment_error;
    logic                  r_ram_enable;
    logic                  r_ram_write;
    logic [ADDR_WIDTH-1:0] r_ram_address;
    logic [7:0]            r_ram_data_out;

    state_t                w_state_next;
    logic [1:0]            w_k_next;
    logic [CW-1:0]         w_wait_next;
    logic                  w_read_write_next;
    logic [1:0]            w_data_type_next;
    logic                  w_sign_extend_next;
    logic [ADDR_WIDTH-1:0] w_address_next;
    logic [31:0]           w_data_next;
    logic                  w_error_next;
    logic [31:0]           w_asm_next;
    logic                  w_misaligned;
    logic [1:0]            w_load_lane;
    logic [1:0]            w_store_lane;
    logic                  w_load_finish;

    function automatic logic [2:0] f_nbytes(input logic [1:0] dt);
        case (dt)
            2'b00:   f_nbytes = 3'd1;
            2'b01:   f_nbytes = 3'd2;
            default: f_nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] f_extend(input logic [31:0] v, input logic [1:0] dt, input logic sx);
        case (dt)
            2'b00:   f_extend = {{24{sx & v[7]}}, v[7:0]};
            2'b01:   f_extend = {{16{sx & v[15]}}, v[15:0]};
            default: f_extend = v;
        endcase
    endfunction

    assign w_misaligned = (i_data_type == 2'b11)
                        || (i_data_type == 2'b01 && i_address[0])
                        || (i_data_type == 2'b10 && i_address[1:0] != 2'b00);

    // Lane of the byte handled at step k: the MSB goes first (big-endian).
    assign w_load_lane  = 2'(f_nbytes(r_data_type) - 3'd1) - r_k;
    assign w_store_lane = 2'(f_nbytes(w_data_type_next) - 3'd1) - w_k_next;

    always_comb begin
        w_state_next       = r_state;
        w_k_next           = r_k;
        w_wait_next        = r_wait_cnt;
        w_read_write_next  = r_read_write;
        w_data_type_next   = r_data_type;
        w_sign_extend_next = r_sign_extend;
        w_address_next     = r_address;
        w_data_next        = r_data;
        w_error_next       = r_error;
        w_asm_next         = r_asm;
        w_load_finish      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_memory_operation_valid) begin
                    w_read_write_next  = i_read_write;
                    w_data_type_next   = i_data_type;
                    w_sign_extend_next = i_sign_extend;
                    w_address_next     = i_address;
                    w_data_next        = i_data_in;
                    w_error_next       = w_misaligned;
                    w_k_next           = 2'd0;
                    w_asm_next         = 32'd0;
                    w_state_next       = w_misaligned ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_wait_next  = '0;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == CW'(RAM_LATENCY - 1)) begin
                    if (r_read_write) begin
                        w_asm_next[{w_load_lane, 3'b000} +: 8] = i_ram_data_in;
                    end
                    w_k_next = r_k + 2'd1;
                    if ((3'(r_k) + 3'd1) < f_nbytes(r_data_type)) begin
                        w_state_next = ST_ACCESS;
                    end else begin
                        w_state_next  = ST_DONE;
                        w_load_finish = r_read_write;
                    end
                end else begin
                    w_wait_next = r_wait_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                if (!i_memory_operation_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state           <= ST_IDLE;
            r_k               <= 2'd0;
            r_wait_cnt        <= '0;
            r_read_write      <= 1'b0;
            r_data_type       <= 2'b00;
            r_sign_extend     <= 1'b0;
            r_address         <= '0;
            r_data            <= 32'd0;
            r_error           <= 1'b0;
            r_asm             <= 32'd0;
            r_data_out        <= 32'd0;
            r_moc             <= 1'b0;
            r_alignment_error <= 1'b0;
            r_ram_enable      <= 1'b0;
            r_ram_write       <= 1'b0;
            r_ram_address     <= '0;
            r_ram_data_out    <= 8'd0;
        end else begin
            r_state           <= w_state_next;
            r_k               <= w_k_next;
            r_wait_cnt        <= w_wait_next;
            r_read_write      <= w_read_write_next;
            r_data_type       <= w_data_type_next;
            r_sign_extend     <= w_sign_extend_next;
            r_address         <= w_address_next;
            r_data            <= w_data_next;
            r_error           <= w_error_next;
            r_asm             <= w_asm_next;
            r_moc             <= (w_state_next == ST_DONE);
            r_alignment_error <= (w_state_next == ST_DONE) && w_error_next;
            r_ram_enable      <= (w_state_next == ST_ACCESS);
            r_ram_write       <= (w_state_next == ST_ACCESS) && !w_read_write_next;
            if (w_state_next == ST_ACCESS) begin
                r_ram_address  <= w_address_next + ADDR_WIDTH'(w_k_next);
                r_ram_data_out <= w_data_next[{w_store_lane, 3'b000} +: 8];
            end
            if (w_load_finish) begin
                r_data_out <= f_extend(w_asm_next, r_data_type, r_sign_extend);
            end
        end
    end

    assign o_data_out                  = r_data_out;
    assign o_memory_operation_complete = r_moc;
    assign o_alignment_error           = r_alignment_error;
    assign o_ram_enable                = r_ram_enable;
    assign o_ram_write                 = r_ram_write;
    assign o_ram_address               = r_ram_address;
    assign o_ram_data_out              = r_ram_data_out;
endmodule

// File: doc/memory_operation_controller.md
# memory_operation_controller

- Services load/store requests from the control unit against a byte-wide synchronous RAM.
- Asserts Memory_Operation_Complete, the signal the microsequencer's condition select tests while it loops on a memory access.
- Sequences big-endian byte, halfword and word transfers as successive byte accesses, assembles and sign/zero-extends load data, and flags misaligned requests so the control unit can raise a trap.

## Interface
- ADDR_WIDTH, 9, RAM byte-address width.
- RAM_LATENCY, 1, cycles (>=1) from a read-enable cycle to valid Ram_Data_In.
- Clk  input  1  system clock; single clock domain, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Memory_Operation_Valid  input  1  request (MOV) from control unit; held high until MOC is seen.
- Read_Write  input  1  1 = load, 0 = store.
- Data_Type  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- Sign_Extend  input  1  loads only: 1 = sign-extend byte/halfword, 0 = zero-extend.
- Address  input  ADDR_WIDTH  byte address of the most significant byte.
- Data_In  input  32  store data, right-justified.
- Data_Out  output  32  load result, right-justified and extended.
- Memory_Operation_Complete  output  1  MOC, operation finished.
- Alignment_Error  output  1  valid while MOC is high; request was misaligned or reserved.
- Ram_Enable  output  1  RAM access strobe.
- Ram_Write  output  1  RAM write enable; qualified by Ram_Enable.
- Ram_Address  output  ADDR_WIDTH  RAM byte address.
- Ram_Data_Out  output  8  RAM write data.
- Ram_Data_In  input  8  RAM read data.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - MOV high: latch Read_Write, Data_Type, Sign_Extend, Address and Data_In; clear byte counter k.
  - Go to ACCESS, or to DONE with error if the request is misaligned.
  - Inputs that change after acceptance are ignored.
- **Byte count N**: 1 for byte, 2 for halfword, 4 for word.
- **Alignment error** when any of these hold: halfword with Address[0]=1; word with Address[1:0]≠0; Data_Type=11.
  - On error: no RAM access, Data_Out is unchanged, Alignment_Error=1 together with MOC.
- **ACCESS** (one cycle per byte)
  - Ram_Enable=1, Ram_Address=latched Address+k, Ram_Write=~Read_Write.
  - Store data: Ram_Data_Out is byte (N-1-k) of the latched data, so the MSB is written first (big-endian).
  - Go to WAIT.
- **WAIT** (exactly RAM_LATENCY cycles)
  - Ram_Enable=0.
  - Load: capture Ram_Data_In into assembly byte (N-1-k) on the edge that ends the final WAIT cycle.
  - Then k+1: if k+1<N go to ACCESS, else go to DONE.
  - Stores also spend the WAIT cycles, so timing does not depend on direction.
- **DONE**
  - MOC=1; Data_Out is valid for a load.
  - Load result: assembled value extended to 32 bits per Sign_Extend; word loads ignore Sign_Extend.
  - Stay in DONE while MOV is high; return to IDLE when MOV is low.
- **MOV dropped mid-operation**: the operation still completes with no abort; DONE lasts one cycle, then IDLE.
- **Address arithmetic**: modulo 2^ADDR_WIDTH. Aligned requests never wrap inside one operation.
- **Reset**: state=IDLE, k=0; Data_Out, MOC, Alignment_Error, Ram_Enable, Ram_Write, Ram_Address and Ram_Data_Out are all 0. Reset during an operation abandons it; no RAM strobe occurs in the cycle after the reset edge.

## Timing
- Cycle 0 is the cycle in which MOV is sampled high in IDLE.
- Aligned request: MOC rises at cycle 1+N·(1+RAM_LATENCY). With L=1 that is cycle 3 for a byte, 5 for a halfword, 9 for a word.
- Misaligned request: MOC and Alignment_Error high at cycle 1.
- Ram_Enable is high in cycles 1, 1+(1+L), 1+2(1+L), … exactly N times.
- Back-to-back requests: MOV must be low for at least one cycle after MOC. A new request is sampled at the earliest in the first IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then word store of 0xA1B2C3D4 at 0x010, L=1:
  - Writes A1, B2, C3, D4 to 0x010–0x013 on Ram_Enable cycles 1, 3, 5, 7.
  - MOC at cycle 9, Alignment_Error=0.
- Byte load at 0x012 (RAM holds 0xC3):
  - Sign_Extend=1 gives Data_Out=0xFFFFFFC3.
  - Sign_Extend=0 gives 0x000000C3.
  - MOC at cycle 3 in both cases.
- Halfword load at 0x010 returns 0xFFFFA1B2 with Sign_Extend=1.
  - With RAM_LATENCY=3, MOC is at cycle 9.
- Misaligned requests (halfword at 0x011, word at 0x012, Data_Type=11):
  - Each gives MOC and Alignment_Error at cycle 1, no Ram_Enable pulse, Data_Out unchanged.
- Handshake:
  - MOV held high 5 cycles past MOC: MOC stays high, no new access starts.
  - MOV dropped at cycle 2 of a word load: operation completes with MOC at cycle 9 for one cycle only.
- Reset at cycle 4 of a word store:
  - All outputs 0 next cycle, only the bytes already strobed are written, FSM is in IDLE.
  - The next request completes normally.
